// File: rtl/adc_frontend_pkg.sv
// Shared definitions for the ADC front-end blocks: capture FSM states and
// the default capture buffer depth.
package adc_frontend_pkg;

  localparam int DEFAULT_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } capture_state_t;

endpackage

// File: rtl/snapshot_capture_if.sv
// Sample stream in / capture buffer write port bundle for snapshot_capture.
// The capture block is the master: it consumes ADC samples and drives the
// buffer write port. The slave side is the ADC front end plus the buffer.
interface snapshot_capture_if #(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 10
);

  logic                adc_valid;
  logic [SAMPLE_W-1:0] adc_data;
  logic                buf_wr_en;
  logic [ADDR_W-1:0]   buf_wr_addr;
  logic [SAMPLE_W-1:0] buf_wr_data;

  modport master (
    input  adc_valid,
    input  adc_data,
    output buf_wr_en,
    output buf_wr_addr,
    output buf_wr_data
  );

  modport slave (
    output adc_valid,
    output adc_data,
    input  buf_wr_en,
    input  buf_wr_addr,
    input  buf_wr_data
  );

endinterface

// File: rtl/snapshot_capture.sv
// Snapshot capture: on a rising edge of stream_enable, writes the next
// min(snap_len, DEPTH) valid ADC samples into the capture buffer starting at
// address 0, then reports completion until stream_enable is dropped.
// Dropping stream_enable mid-capture aborts with a one-cycle pulse.
module snapshot_capture
  import adc_frontend_pkg::*;
#(
  parameter  int SAMPLE_W = 16,
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int LEN_W    = 32,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stream_enable,
  input  logic [LEN_W-1:0]     snap_len,
  snapshot_capture_if.master   bus,
  output logic                 snapshot_done,
  output logic                 capture_abort,
  output logic [ADDR_W:0]      sample_count
);

  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  capture_state_t state, state_next;

  logic            enable_q;
  logic            start_edge;
  logic [ADDR_W:0] len_clamped;
  logic [ADDR_W:0] len_q;
  logic            load;
  logic            accept;
  logic            abort;

  assign start_edge    = stream_enable & ~enable_q;
  assign snapshot_done = (state == DONE);

  // Clamp the requested length to the buffer depth so the address never wraps
  always_comb begin
    len_clamped = snap_len[ADDR_W:0];
    if (snap_len > DEPTH_LEN) begin
      len_clamped = DEPTH_CNT;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the load/accept/abort strobes for the datapath
  always_comb begin
    state_next = state;
    load       = 1'b0;
    accept     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          load       = 1'b1;
          state_next = (len_clamped == '0) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (!stream_enable) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (bus.adc_valid) begin
          accept = 1'b1;
          if ((sample_count + 1'b1) == len_q) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (!stream_enable) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Enable history for edge detection and length latched at the start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= 1'b0;
      len_q    <= '0;
    end else begin
      enable_q <= stream_enable;
      if (load) begin
        len_q <= len_clamped;
      end
    end
  end

  // Sample counter: cleared on start, saturating at the buffer depth
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_count <= '0;
    end else if (load) begin
      sample_count <= '0;
    end else if (accept && (sample_count != DEPTH_CNT)) begin
      sample_count <= sample_count + 1'b1;
    end
  end

  // Registered buffer write port and abort pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.buf_wr_en   <= 1'b0;
      bus.buf_wr_addr <= '0;
      bus.buf_wr_data <= '0;
      capture_abort   <= 1'b0;
    end else begin
      bus.buf_wr_en <= accept;
      if (accept) begin
        bus.buf_wr_addr <= sample_count[ADDR_W-1:0];
        bus.buf_wr_data <= SAMPLE_W'(bus.adc_data);
      end
      capture_abort <= abort;
    end
  end

endmodule

// File: tb/tb_snapshot_capture.sv
// Directed testbench for snapshot_capture with a write scoreboard.
// Stimulus pushes each expected buffer write; the monitor pops and compares
// on every buf_wr_en it observes.
module tb_snapshot_capture;

  localparam int SAMPLE_W = 16;
  localparam int DEPTH    = 1024;
  localparam int LEN_W    = 32;
  localparam int ADDR_W   = 10;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [SAMPLE_W-1:0] data;
  } wr_t;

  logic             clk;
  logic             rst;
  logic             stream_enable;
  logic [LEN_W-1:0] snap_len;
  logic             snapshot_done;
  logic             capture_abort;
  logic [ADDR_W:0]  sample_count;

  int  checks;
  int  errors;
  wr_t exp_q[$];

  snapshot_capture_if #(.SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)) bus ();

  snapshot_capture #(
    .SAMPLE_W(SAMPLE_W),
    .DEPTH   (DEPTH),
    .LEN_W   (LEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stream_enable(stream_enable),
    .snap_len     (snap_len),
    .bus          (bus),
    .snapshot_done(snapshot_done),
    .capture_abort(capture_abort),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench always ends
  initial begin
    #2000000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Scoreboard monitor: every observed write must match the oldest expected one
  always @(negedge clk) begin
    if (bus.buf_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write actual addr=%0d data=%h required=no write",
                 bus.buf_wr_addr, bus.buf_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.buf_wr_addr !== e.addr || bus.buf_wr_data !== e.data) begin
          errors++;
          $display("[TB] FAIL write actual addr=%0d data=%h required addr=%0d data=%h",
                   bus.buf_wr_addr, bus.buf_wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, optionally record the write it must cause,
  // then advance to just after the next rising edge.
  task automatic applyStimulus(input logic en, input logic valid,
                               input logic [SAMPLE_W-1:0] data,
                               input bit expect_write, input int addr);
    wr_t e;
    stream_enable = en;
    bus.adc_valid = valid;
    bus.adc_data  = data;
    if (expect_write) begin
      e.addr = ADDR_W'(addr);
      e.data = data;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    stream_enable = 1'b0;
    snap_len      = '0;
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;

    // Reset state
    applyStimulus(0, 0, 16'h0, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 0);
    checkOutput("rst_wr_en", 32'(bus.buf_wr_en), 0);
    checkOutput("rst_done", 32'(snapshot_done), 0);
    checkOutput("rst_abort", 32'(capture_abort), 0);
    checkOutput("rst_count", 32'(sample_count), 0);
    rst = 1'b0;
    applyStimulus(0, 0, 16'h0, 0, 0);

    // Length 8, continuous valid
    $display("[TB] length 8 continuous");
    snap_len = 8;
    applyStimulus(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 16'hA000 + 16'(i), 1, i);
    end
    checkOutput("len8_done", 32'(snapshot_done), 1);
    checkOutput("len8_final_wr", 32'(bus.buf_wr_en), 1);
    checkOutput("len8_count", 32'(sample_count), 8);
    // Enable held high in DONE: no restart, no writes
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 16'hEEEE, 0, 0);
    end
    checkOutput("len8_hold_done", 32'(snapshot_done), 1);
    checkOutput("len8_hold_count", 32'(sample_count), 8);
    applyStimulus(0, 0, 16'h0, 0, 0);
    checkOutput("len8_release", 32'(snapshot_done), 0);

    // Length 5, valid on alternate cycles
    $display("[TB] length 5 alternate valid");
    snap_len = 5;
    applyStimulus(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        applyStimulus(1, 1, 16'hB000 + 16'(i), 1, i / 2);
      end else begin
        applyStimulus(1, 0, 16'hDEAD, 0, 0);
      end
    end
    applyStimulus(1, 1, 16'hCCCC, 0, 0);
    applyStimulus(1, 1, 16'hCCCD, 0, 0);
    checkOutput("alt_done", 32'(snapshot_done), 1);
    checkOutput("alt_count", 32'(sample_count), 5);
    applyStimulus(0, 0, 16'h0, 0, 0);

    // Length above depth is clamped to 1024 writes
    $display("[TB] length 4096 clamped");
    snap_len = 4096;
    applyStimulus(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 1100; i++) begin
      applyStimulus(1, 1, 16'(i) ^ 16'h5A5A, i < DEPTH, i);
    end
    checkOutput("clamp_done", 32'(snapshot_done), 1);
    checkOutput("clamp_count", 32'(sample_count), DEPTH);
    applyStimulus(0, 0, 16'h0, 0, 0);

    // Zero length goes straight to DONE with no writes
    $display("[TB] length 0");
    snap_len = 0;
    applyStimulus(1, 1, 16'h1111, 0, 0);
    checkOutput("zero_done", 32'(snapshot_done), 1);
    checkOutput("zero_count", 32'(sample_count), 0);
    checkOutput("zero_wr_en", 32'(bus.buf_wr_en), 0);
    applyStimulus(0, 0, 16'h0, 0, 0);

    // Abort after 3 of 10; the sample coinciding with the drop is discarded
    $display("[TB] abort");
    snap_len = 10;
    applyStimulus(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 16'hC000 + 16'(i), 1, i);
    end
    applyStimulus(0, 1, 16'hBAD0, 0, 0);
    checkOutput("abort_pulse", 32'(capture_abort), 1);
    checkOutput("abort_done", 32'(snapshot_done), 0);
    checkOutput("abort_count", 32'(sample_count), 3);
    applyStimulus(0, 0, 16'h0, 0, 0);
    checkOutput("abort_single", 32'(capture_abort), 0);
    snap_len = 2;
    applyStimulus(1, 0, 16'h0, 0, 0);
    applyStimulus(1, 1, 16'hC100, 1, 0);
    applyStimulus(1, 1, 16'hC101, 1, 1);
    checkOutput("reen_done", 32'(snapshot_done), 1);
    applyStimulus(0, 0, 16'h0, 0, 0);

    // Reset mid-capture with enable held high, then a fresh capture
    $display("[TB] reset mid-capture");
    snap_len = 6;
    applyStimulus(1, 0, 16'h0, 0, 0);
    applyStimulus(1, 1, 16'hD000, 1, 0);
    applyStimulus(1, 1, 16'hD001, 1, 1);
    rst = 1'b1;
    applyStimulus(1, 0, 16'h0, 0, 0);
    checkOutput("mid_rst_wr_en", 32'(bus.buf_wr_en), 0);
    checkOutput("mid_rst_done", 32'(snapshot_done), 0);
    checkOutput("mid_rst_abort", 32'(capture_abort), 0);
    checkOutput("mid_rst_count", 32'(sample_count), 0);
    rst      = 1'b0;
    snap_len = 3;
    applyStimulus(1, 0, 16'h0, 0, 0);
    checkOutput("post_rst_no_abort", 32'(capture_abort), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 16'hD100 + 16'(i), 1, i);
    end
    checkOutput("post_rst_done", 32'(snapshot_done), 1);
    checkOutput("post_rst_count", 32'(sample_count), 3);
    applyStimulus(0, 0, 16'h0, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 0);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/snapshot_capture.md
SNAPSHOT_CAPTURE -- requirements
Module: snapshot_capture

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, meaning ADC sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning capture buffer depth in samples (power of two).
REQ-003 SHALL have parameter LEN_W, default 32, meaning width of snap_len, matching the CSR data width.
REQ-004 SHALL have derived localparam ADDR_W = $clog2(DEPTH).
REQ-005 SHALL have: clk  input  1  single clock for all logic.
REQ-006 SHALL have: rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have: stream_enable  input  1  capture enable from the CSR block.
REQ-008 SHALL have: snap_len  input  LEN_W  requested sample count from the CSR block.
REQ-009 SHALL have: adc_valid  input  1  sample strobe from the ADC front end.
REQ-010 SHALL have: adc_data  input  SAMPLE_W  ADC sample, qualified by adc_valid.
REQ-011 SHALL have: buf_wr_en  output  1  buffer write strobe.
REQ-012 SHALL have: buf_wr_addr  output  ADDR_W  buffer write address.
REQ-013 SHALL have: buf_wr_data  output  SAMPLE_W  buffer write data.
REQ-014 SHALL have: snapshot_done  output  1  capture complete, returned to the CSR status register.
REQ-015 SHALL have: capture_abort  output  1  one-cycle pulse when a capture is aborted.
REQ-016 SHALL have: sample_count  output  ADDR_W+1  number of samples written in the current or last capture.

Function
REQ-017 SHALL implement FSM states IDLE, CAPTURE and DONE.
REQ-018 IDLE->CAPTURE SHALL occur on a rising edge of stream_enable (registered 0->1) when the clamped length is nonzero; the FSM SHALL clear sample_count on this transition.
REQ-019 The clamped length SHALL be min(snap_len, DEPTH), latched on the start edge; later snap_len changes SHALL have no effect on a capture in progress.
REQ-020 A start edge with snap_len==0 SHALL go IDLE->DONE directly with sample_count=0.
REQ-021 In CAPTURE, each cycle with adc_valid=1 SHALL write one sample: buf_wr_en=1 one cycle later, with buf_wr_addr=sample_count (before increment) and buf_wr_data=adc_data registered.
REQ-022 Samples with adc_valid=0 SHALL not be written; there is no back-pressure, and the block SHALL accept every valid sample while in CAPTURE.
REQ-023 CAPTURE->DONE SHALL occur on the cycle the final sample is accepted (sample_count reaches the clamped length); the final write SHALL still issue on the next cycle.
REQ-024 In DONE, snapshot_done SHALL be 1 and held, and buf_wr_en SHALL be 0.
REQ-025 DONE->IDLE SHALL occur when stream_enable=0; snapshot_done SHALL drop in the same cycle.
REQ-026 If stream_enable=0 during CAPTURE, the FSM SHALL go CAPTURE->IDLE, pulse capture_abort for 1 cycle, leave snapshot_done at 0 and hold sample_count.
REQ-027 If stream_enable deasserts and adc_valid=1 in the same cycle, abort SHALL win and that sample SHALL not be written.
REQ-028 stream_enable held high after DONE SHALL NOT restart a capture; a new 0->1 edge SHALL be required.
REQ-029 sample_count SHALL saturate at DEPTH, and buf_wr_addr SHALL never wrap within one capture.

Reset
REQ-030 With rst=1 at a clk edge, the FSM SHALL be IDLE and buf_wr_en, snapshot_done, capture_abort and sample_count SHALL all be 0.
REQ-031 The edge-detect history register SHALL reset to 0, so stream_enable already high when rst releases SHALL be treated as a start edge.
REQ-032 Reset asserted mid-CAPTURE SHALL abandon the capture without a capture_abort pulse.

Structure
REQ-033 The state enum (IDLE, CAPTURE, DONE) SHALL live in the shared package adc_frontend_pkg, and DEPTH SHALL default to a package constant there.
REQ-034 The design SHALL be a single module with no sub-modules; the rising-edge detect SHALL be inline.

Verification
REQ-035 snap_len=8, stream_enable 0->1, adc_valid continuous -> 8 writes at addresses 0..7 with matching data, snapshot_done=1 at cycle 9 after the start edge, sample_count=8.
REQ-036 snap_len=5, adc_valid on alternate cycles -> exactly 5 writes at addresses 0..4, no writes on invalid cycles, then DONE.
REQ-037 snap_len=4096 with DEPTH=1024 -> 1024 writes at addresses 0..1023, sample_count=1024, no address wrap.
REQ-038 snap_len=0, start edge -> snapshot_done=1 on the next cycle, no buf_wr_en.
REQ-039 stream_enable dropped after 3 samples of snap_len=10 -> capture_abort pulses once, sample_count=3, snapshot_done=0; re-enable starts at address 0.
REQ-040 rst pulsed mid-capture with stream_enable held high -> all outputs 0, then a fresh capture restarts from address 0.
